// File: rtl/vrb_pkg.sv
// Shared types and lane helpers for the vector register bank.
// Lane merge is written against a maximum register width so one function serves any LANES/WIDTH.
package vrb_pkg;

    typedef enum logic {
        VRB_CLEAR,
        VRB_IDLE
    } vrb_state_e;

    localparam int VRB_MAXL = 32;
    localparam int VRB_MAXB = 1024;
    localparam int VRB_LAW  = $clog2(VRB_MAXL);
    localparam int VRB_BAW  = $clog2(VRB_MAXB);

    function automatic logic vrb_lane_sel(input logic [VRB_MAXL-1:0] mask,
                                          input int unsigned lane);
        return (lane < VRB_MAXL) ? mask[VRB_LAW'(lane)] : 1'b0;
    endfunction

    // Bits of lanes selected by mask come from new_v, all others from old_v.
    function automatic logic [VRB_MAXB-1:0] vrb_merge(input logic [VRB_MAXB-1:0] old_v,
                                                      input logic [VRB_MAXB-1:0] new_v,
                                                      input logic [VRB_MAXL-1:0] mask,
                                                      input int unsigned width,
                                                      input int unsigned lanes);
        logic [VRB_MAXB-1:0] bm;
        bm = '0;
        for (int unsigned i = 0; i < VRB_MAXB; i++) begin
            if (width != 0 && (i / width) < lanes && vrb_lane_sel(mask, i / width))
                bm[VRB_BAW'(i)] = 1'b1;
        end
        return (old_v & ~bm) | (new_v & bm);
    endfunction

endpackage

// File: rtl/vrb_clear_fsm.sv
// Reset clear-sweep controller: walks clr_addr over every register once after reset.
module vrb_clear_fsm
    import vrb_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    vrb_state_e    state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= VRB_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                VRB_CLEAR: begin
                    if (ptr_q == LAST) begin
                        state_q <= VRB_IDLE;
                        ptr_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                VRB_IDLE: begin
                end
                default: begin
                    state_q <= VRB_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign clr_we_o   = busy_q;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/vec_reg_bank.sv
// Multi-lane vector register bank: 2 combinational read ports, 1 masked write port, reset clear sweep.
// Define VRB_BYPASS_EN to forward same-cycle writes to the read ports.
module vec_reg_bank
    import vrb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int LANES = 4,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WE3,
    input  logic [LANES-1:0]       WM3,
    input  logic [AW-1:0]          RA1,
    input  logic [AW-1:0]          RA2,
    input  logic [AW-1:0]          RA3,
    input  logic [LANES*WIDTH-1:0] WD3,
    output logic [LANES*WIDTH-1:0] RD1,
    output logic [LANES*WIDTH-1:0] RD2,
    output logic                   BUSY
);

    localparam int            BITS    = LANES * WIDTH;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    logic [BITS-1:0] rb_q [DEPTH];
    logic            busy;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            ra1_ok, ra2_ok, ra3_ok;
    logic            user_we;
    logic            wr_en_d;
    logic [AW-1:0]   wr_addr_d;
    logic [BITS-1:0] wr_data_d;

    function automatic logic [BITS-1:0] merge_lanes(input logic [BITS-1:0]  old_v,
                                                    input logic [BITS-1:0]  new_v,
                                                    input logic [LANES-1:0] mask);
        logic [VRB_MAXB-1:0] full;
        full = vrb_merge(VRB_MAXB'(old_v), VRB_MAXB'(new_v), VRB_MAXL'(mask), WIDTH, LANES);
        return full[BITS-1:0];
    endfunction

    vrb_clear_fsm #(
        .DEPTH(DEPTH)
    ) u_clear_fsm (
        .clk_i     (CLK),
        .rst_i     (RST),
        .busy_o    (busy),
        .clr_we_o  (clr_we),
        .clr_addr_o(clr_addr)
    );

    assign BUSY    = busy;
    assign ra1_ok  = {1'b0, RA1} < DEPTH_C;
    assign ra2_ok  = {1'b0, RA2} < DEPTH_C;
    assign ra3_ok  = {1'b0, RA3} < DEPTH_C;
    assign user_we = WE3 & ~busy & ra3_ok;

    // Single storage write port: the sweep has priority; a reset edge leaves storage untouched.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = RA3;
        wr_data_d = '0;
        if (!RST) begin
            if (clr_we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_addr;
            end else if (user_we) begin
                wr_en_d   = 1'b1;
                wr_data_d = merge_lanes(rb_q[RA3], WD3, WM3);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_d)
            rb_q[wr_addr_d] <= wr_data_d;
    end

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (!busy) begin
            if (ra1_ok) begin
                RD1 = rb_q[RA1];
`ifdef VRB_BYPASS_EN
                if (user_we && RA1 == RA3)
                    RD1 = merge_lanes(rb_q[RA1], WD3, WM3);
`endif
            end
            if (ra2_ok) begin
                RD2 = rb_q[RA2];
`ifdef VRB_BYPASS_EN
                if (user_we && RA2 == RA3)
                    RD2 = merge_lanes(rb_q[RA2], WD3, WM3);
`endif
            end
        end
    end

endmodule

// File: tb/tb_vec_reg_bank.sv
// Self-checking bench: a DEPTH=32 and a DEPTH=20 bank share stimulus and are compared to a behavioural model.
module tb_vec_reg_bank;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic         WE3 = 1'b0;
    logic [3:0]   WM3 = '0;
    logic [4:0]   RA1 = '0, RA2 = '0, RA3 = '0;
    logic [127:0] WD3 = '0;
    logic [127:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic         busy_a, busy_b;

    int passed = 0;
    int total  = 0;

    logic [127:0] mem [2][32];
    int           dep [2] = '{32, 20};
    int           clr [2] = '{0, 0};
    bit           known = 0;

    always #5 clk = ~clk;

    vec_reg_bank #(.WIDTH(32), .LANES(4), .DEPTH(32)) u_dut32 (
        .CLK(clk), .RST(RST), .WE3(WE3), .WM3(WM3), .RA1(RA1), .RA2(RA2), .RA3(RA3),
        .WD3(WD3), .RD1(rd1_a), .RD2(rd2_a), .BUSY(busy_a)
    );

    vec_reg_bank #(.WIDTH(32), .LANES(4), .DEPTH(20)) u_dut20 (
        .CLK(clk), .RST(RST), .WE3(WE3), .WM3(WM3), .RA1(RA1), .RA2(RA2), .RA3(RA3),
        .WD3(WD3), .RD1(rd1_b), .RD2(rd2_b), .BUSY(busy_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] exp_rd(input int d, input logic [4:0] ra);
        logic [127:0] v;
        if (clr[d] > 0 || int'(ra) >= dep[d]) return '0;
        v = mem[d][ra];
`ifdef VRB_BYPASS_EN
        if (WE3 && ra == RA3)
            for (int k = 0; k < 4; k++)
                if (WM3[k]) v[k*32 +: 32] = WD3[k*32 +: 32];
`endif
        return v;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (RST) begin
                clr[d] = dep[d];
            end else if (clr[d] > 0) begin
                clr[d]--;
                if (clr[d] == 0)
                    for (int a = 0; a < 32; a++) mem[d][a] = '0;
            end else if (WE3 && int'(RA3) < dep[d]) begin
                for (int k = 0; k < 4; k++)
                    if (WM3[k]) mem[d][RA3][k*32 +: 32] = WD3[k*32 +: 32];
            end
        end
        if (RST) known = 1;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        if (known) begin
            chk("busy32", {127'd0, busy_a}, {127'd0, clr[0] > 0});
            chk("busy20", {127'd0, busy_b}, {127'd0, clr[1] > 0});
            chk("rd1_32", rd1_a, exp_rd(0, RA1));
            chk("rd2_32", rd2_a, exp_rd(0, RA2));
            chk("rd1_20", rd1_b, exp_rd(1, RA1));
            chk("rd2_20", rd2_b, exp_rd(1, RA2));
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        cyc_begin();
        cyc_end();
    endtask

    task automatic write(input logic [4:0] a, input logic [127:0] d, input logic [3:0] m);
        WE3 = 1'b1; RA3 = a; WD3 = d; WM3 = m;
        cyc();
        WE3 = 1'b0;
    endtask

    initial begin : stim
        int n32, n20;
        logic [127:0] old7;

        // Reset pulse with writes to r3 held through the whole sweep, including the edge BUSY falls
        RST = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        RST = 1'b0;
        n32 = 0; n20 = 0;
        for (int i = 0; i < 40; i++) begin
            WE3 = (i < 32); RA3 = 5'd3; WM3 = 4'hF;
            WD3 = {$urandom, $urandom, $urandom, $urandom};
            RA1 = 5'($urandom_range(0, 31)); RA2 = 5'($urandom_range(0, 31));
            cyc_begin();
            n32 += int'(busy_a === 1'b1);
            n20 += int'(busy_b === 1'b1);
            cyc_end();
        end
        WE3 = 1'b0;
        chk("sweep_len32", 128'(n32), 128'd32);
        chk("sweep_len20", 128'(n20), 128'd20);
        RA1 = 5'd3;
        cyc_begin();
        chk("dropped_r3", rd1_a, '0);
        cyc_end();

        // Masked lane write
        write(5'd5, 128'h11111111_22222222_33333333_44444444, 4'hF);
        write(5'd5, {4{32'hAAAAAAAA}}, 4'b0101);
        write(5'd9, {4{32'h5555AAAA}}, 4'h0);
        RA1 = 5'd5; RA2 = 5'd9;
        cyc_begin();
        chk("masked_r5_32", rd1_a, 128'h11111111_AAAAAAAA_33333333_AAAAAAAA);
        chk("masked_r5_20", rd1_b, 128'h11111111_AAAAAAAA_33333333_AAAAAAAA);
        chk("mask0_r9", rd2_a, '0);
        cyc_end();

        // Same-cycle read and write of r7
        old7 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        write(5'd7, old7, 4'hF);
        RA1 = 5'd7; RA3 = 5'd7; WE3 = 1'b1; WM3 = 4'hF; WD3 = {4{32'hDEADBEEF}};
        cyc_begin();
`ifdef VRB_BYPASS_EN
        chk("rw_same_cycle", rd1_a, {4{32'hDEADBEEF}});
`else
        chk("rw_same_cycle", rd1_a, old7);
`endif
        cyc_end();
        WE3 = 1'b0;
        cyc_begin();
        chk("rw_after_edge", rd1_a, {4{32'hDEADBEEF}});
        cyc_end();

        // Out-of-range address on the DEPTH=20 bank
        write(5'd19, {4{32'h19191919}}, 4'hF);
        write(5'd25, {4{32'h25252525}}, 4'hF);
        RA1 = 5'd25; RA2 = 5'd19;
        cyc_begin();
        chk("oor_rd25_20", rd1_b, '0);
        chk("oor_rd19_20", rd2_b, {4{32'h19191919}});
        chk("inrange_rd25_32", rd1_a, {4{32'h25252525}});
        cyc_end();

        // Reset reasserted ten cycles into a sweep
        write(5'd31, {4{32'h31313131}}, 4'hF);
        RST = 1'b1; cyc(); RST = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        RST = 1'b1; cyc(); RST = 1'b0;
        n32 = 0;
        for (int i = 0; i < 40; i++) begin
            RA1 = 5'd31; RA2 = 5'($urandom_range(0, 31));
            cyc_begin();
            n32 += int'(busy_a === 1'b1);
            cyc_end();
        end
        chk("restart_len32", 128'(n32), 128'd32);
        RA1 = 5'd31;
        cyc_begin();
        chk("restart_r31", rd1_a, '0);
        cyc_end();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            WE3 = $urandom_range(0, 2) != 0;
            WM3 = 4'($urandom);
            WD3 = {$urandom, $urandom, $urandom, $urandom};
            RA1 = 5'($urandom);
            RA2 = ($urandom_range(0, 3) == 0) ? RA1 : 5'($urandom);
            RA3 = ($urandom_range(0, 2) == 0) ? RA1 : 5'($urandom);
            cyc();
        end
        RST = 1'b0; WE3 = 1'b0;
        for (int i = 0; i < 40; i++) cyc();

        // Final sweep of every address through both ports
        for (int a = 0; a < 32; a += 2) begin
            RA1 = 5'(a); RA2 = 5'(a + 1);
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
